bcd_seg_driver: RTL and testbench
=================================

# bcd_seg_driver

Sequential binary-to-decimal display driver: converts an unsigned IN_W-bit value into DIGITS BCD digits using shift-and-add-3 (double dabble), one bit per clock. It drives one active-low 7-segment pattern per digit. It is the parametrised successor of the fixed two-digit combinational translator, and sits between switch/counter logic and the board HEX displays. Results are registered, so the displays never glitch during a conversion.

## Interface
- IN_W, 8: width of the binary input, ≥1.
- DIGITS, 3: number of decimal digits. Must be ≥ ceil(IN_W·log10 2); smaller values are an elaboration error.
- clk  in  1: system clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request a conversion of bin. Sampled only in IDLE.
- bin  in  IN_W: unsigned value, captured on the accepted start edge.
- busy  out  1: high while a conversion is in progress (SHIFT state).
- done  out  1: one-cycle pulse when new results appear on bcd/hex.
- bcd  out  4·DIGITS: digit k at bcd[4k+3:4k], with digit 0 least significant.
- hex  out  7·DIGITS: digit k at hex[7k+6:7k].
  - Bit 7k+6 is segment a and bit 7k is segment g.
  - A segment is lit by 0, so 0 shows as 7'b0000001.

## Operation
- States:
  - IDLE: wait for start. Outputs hold the last result.
  - SHIFT: run the conversion.
  - DONE: commit results. Lasts exactly one cycle, then returns to IDLE.
- IDLE with start=1: capture bin into the shift register, clear the BCD scratch, load bit counter = IN_W, go to SHIFT.
- SHIFT, each cycle:
  - Every scratch digit ≥5 gets +3, all digits in parallel.
  - The {scratch, shift register} pair shifts left by 1; the MSB of the shift register enters scratch bit 0.
  - The counter decrements. When it reaches 0, go to DONE.
- DONE:
  - Copy scratch to bcd and decode each digit into hex.
  - Assert done for this cycle, then go to IDLE.
- start is ignored in SHIFT and DONE. There is no queueing, and a held-high start does not retrigger until IDLE.
- A start presented in the IDLE cycle right after DONE is accepted (back-to-back conversions).
- Digit codes 10–15 cannot occur. The decoder maps them to blank (7'b1111111).
- Arithmetic: the scratch register is 4·DIGITS bits. The add-3 step is per 4-bit digit with no inter-digit carry.

## Timing
- Reset values: busy=0, done=0, bcd=0, all hex digits blank (7'b1111111), state IDLE, scratch and counter 0.
- Latency: start sampled at edge E0. busy is high after E0 through the last shift edge E(IN_W). done and the new bcd/hex are valid after edge E(IN_W+1), i.e. IN_W+1 cycles after start.
- Throughput: one conversion per IN_W+2 cycles with start held high.
- Reset asserted mid-conversion aborts immediately: outputs go to reset values and the partial result is never presented.
- bin may change freely after the start edge.

## Configuration
- BCD_SEG_LZB_EN defined: leading-zero blanking.
  - Any digit k>0 whose value and all more-significant digits are zero is blanked (7'b1111111).
  - Digit 0 is always shown, so the value 0 displays as a single "0".
  - bcd is unaffected.
- Not defined: every digit is decoded, including leading zeros.

## Structure
- Package bcd_seg_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK (active-low, a..g MSB-first);
  - the state encoding IDLE/SHIFT/DONE;
  - a function computing the minimum DIGITS for a given IN_W.
- Sub-module seg7_dec: combinational 4-bit → 7-segment decoder plus a blank input. It is instantiated DIGITS times from a generate loop.

## Test plan
- Default parameters, bin=0, start pulse:
  - done after 9 cycles, bcd=12'h000.
  - Macro off: all three hex digits = 7'b0000001.
  - Macro on: digit 0 = 7'b0000001, digits 1–2 = 7'b1111111.
- bin=8'd10: digit 1 = 7'b1001111, digit 0 = 7'b0000001, bcd=12'h010.
- bin=8'd255: bcd=12'h255. hex digits 2/1/0 = 7'b0010010 / 7'b0100100 / 7'b0100100. busy high for exactly 8 cycles.
- Start bin=8'd37, then pulse start with bin=8'd99 during SHIFT: the second start is ignored, result 12'h037, a single done pulse.
- Start bin=8'd200, assert rst_n=0 on the 4th SHIFT cycle: outputs immediately take reset values, and no done occurs. After release, bin=8'd7 converts to 12'h007.
- IN_W=16, DIGITS=5, bin=16'hFFFF: done after 17 cycles, bcd=20'h65535. Back-to-back start with bin=16'd1 gives 20'h00001 after a further 18 cycles.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the BCD 7-segment display driver:
// active-low segment patterns, the converter state encoding and a helper
// that returns the number of decimal digits an unsigned width can need.
package bcd_seg_pkg;

    // Segment patterns, bit 6 = segment a ... bit 0 = segment g, lit by 0.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Converter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ceil(in_w * log10(2)) using a fixed-point log10(2) = 0.30103.
    // in_w * log10(2) is never an exact integer, so the rounding is safe.
    function automatic int min_digits(input int in_w);
        return (in_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low 7-segment decoder with a blank
// override. Codes 10..15 are not valid BCD and show as blank.
module seg7_dec
    import bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode one digit, forcing all segments off when blank is set.
    always_comb begin
        // NOTE: seg is given a default before any branch so every path assigns it and no latch is inferred.
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_driver.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving one registered active-low 7-segment pattern per decimal digit.
// Results only change in the single cycle after a conversion completes, so
// the displays never show intermediate values.
//
// Optional feature: define BCD_SEG_LZB_EN for leading-zero blanking of the
// hex outputs (digit 0 always shown; bcd output unaffected).
module bcd_seg_driver
    import bcd_seg_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int HEX_W = 7 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Refuse to build a converter that cannot hold the largest input value.
    generate
        if (IN_W < 1) begin : g_bad_width
            $error("bcd_seg_driver: IN_W must be at least 1");
        end
        if (DIGITS < min_digits(IN_W)) begin : g_bad_digits
            $error("bcd_seg_driver: DIGITS too small for IN_W");
        end
    endgenerate

    state_e           state_q,   state_d;
    logic [IN_W-1:0]  sreg_q,    sreg_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [SCR_W-1:0] bcd_q,     bcd_d;
    logic [HEX_W-1:0] hex_q,     hex_d;
    logic             done_q,    done_d;

    logic [SCR_W-1:0] scratch_adj;
    logic [DIGITS-1:0] blank;
    logic [HEX_W-1:0] hex_dec;

    // Add-3 correction: each digit >= 5 gets +3 independently, no carries.
    always_comb begin
        scratch_adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef BCD_SEG_LZB_EN
    logic lead_zero;

    // Blank digits above digit 0 while they and everything above are zero.
    always_comb begin
        lead_zero = 1'b1;
        blank     = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            lead_zero = lead_zero & (scratch_q[4*k +: 4] == 4'd0);
            blank[k]  = lead_zero;
        end
    end
`else
    // Every digit is shown, including leading zeros.
    always_comb begin
        blank = '0;
    end
`endif

    // One decoder per digit, fed from the finished scratch value.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_dec
            seg7_dec u_dec (
                .digit (scratch_q[4*k +: 4]),
                .blank (blank[k]),
                .seg   (hex_dec[7*k +: 7])
            );
        end
    endgenerate

    // Next-state and datapath: load on start, shift IN_W times, then commit.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        hex_d     = hex_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d    = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {scratch_adj[SCR_W-2:0], sreg_q[IN_W-1]};
                sreg_d    = sreg_q << 1;
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                hex_d   = hex_dec;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            hex_q     <= {DIGITS{SEG_BLANK}};
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            hex_q     <= hex_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign hex  = hex_q;

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Bench for bcd_seg_driver: an 8-bit/3-digit instance driven from a vector
// table plus hand-written corner sequences, and a 16-bit/5-digit instance
// for the wide and back-to-back cases. Expected results go into a queue when
// start is driven and are compared when the DUT pulses done.
module tb_bcd_seg_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8,  start16;
    logic [7:0]  bin8;
    logic [15:0] bin16;
    logic        busy8,   busy16;
    logic        done8,   done16;
    logic [11:0] bcd8;
    logic [19:0] bcd16;
    logic [20:0] hex8;
    logic [34:0] hex16;

    always #5 clk = ~clk;

    bcd_seg_driver #(.IN_W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8),
        .hex   (hex8)
    );

    bcd_seg_driver #(.IN_W(16), .DIGITS(5)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .bin   (bin16),
        .busy  (busy16),
        .done  (done16),
        .bcd   (bcd16),
        .hex   (hex16)
    );

    typedef struct {
        logic [19:0] bcd;
        logic [34:0] hex;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    exp_t q8[$];
    exp_t q16[$];
    vec_t vecs[8];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int busy_cnt8 = 0;

    localparam logic [6:0] B_BLANK = 7'b1111111;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [34:0] model_hex(input logic [19:0] b, input int nd);
        logic [34:0] h;
        logic [3:0]  d;
        bit          lead;
        h    = '1;
        lead = 1'b1;
        for (int k = nd - 1; k >= 0; k--) begin
            d = b[4*k +: 4];
`ifdef BCD_SEG_LZB_EN
            lead = lead && (d == 4'd0) && (k > 0);
            h[7*k +: 7] = lead ? 7'b1111111 : seg_of(d);
`else
            h[7*k +: 7] = seg_of(d);
`endif
        end
        return h;
    endfunction

    // Scoreboard for the 8-bit instance: every done must match a queued result.
    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("dut8 spurious done", done8, 1'b0);
            end else begin
                e = q8.pop_front();
                check("dut8 bcd",        bcd8, e.bcd[11:0]);
                check("dut8 hex",        hex8, e.hex[20:0]);
                check("dut8 done cycle", cyc,  e.due);
            end
        end
        if (busy8 === 1'b1) busy_cnt8++;
    end

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("dut16 spurious done", done16, 1'b0);
            end else begin
                e = q16.pop_front();
                check("dut16 bcd",        bcd16, e.bcd);
                check("dut16 hex",        hex16, e.hex);
                check("dut16 done cycle", cyc,   e.due);
            end
        end
    end

    // Pulse start for one cycle and queue the expected result (done 9 edges after E0).
    task automatic run8(input logic [7:0] b, input logic [11:0] exp_bcd, input logic [20:0] exp_hex);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = b;
        @(negedge clk);
        start8 = 1'b0;
        bin8   = 8'($urandom);
        e.bcd  = 20'(exp_bcd);
        e.hex  = 35'(exp_hex);
        e.due  = cyc + 9;
        q8.push_back(e);
    endtask

    task automatic wait8(input int budget);
        int n = 0;
        while (q8.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("dut8 done timeout", q8.size(), 0);
    endtask

    task automatic wait16(input int budget);
        int n = 0;
        while (q16.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("dut16 done timeout", q16.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [20:0] hex_zero;
        logic [20:0] hex_ten;

        vecs[0] = '{8'd1,   12'h001};
        vecs[1] = '{8'd9,   12'h009};
        vecs[2] = '{8'd19,  12'h019};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd128, 12'h128};
        vecs[5] = '{8'd199, 12'h199};
        vecs[6] = '{8'd64,  12'h064};
        vecs[7] = '{8'd250, 12'h250};

`ifdef BCD_SEG_LZB_EN
        hex_zero = {7'b1111111, 7'b1111111, 7'b0000001};
        hex_ten  = {7'b1111111, 7'b1001111, 7'b0000001};
`else
        hex_zero = {7'b0000001, 7'b0000001, 7'b0000001};
        hex_ten  = {7'b0000001, 7'b1001111, 7'b0000001};
`endif

        rst_n   = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        bin8    = '0;
        bin16   = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset busy",  busy8, 1'b0);
        check("reset done",  done8, 1'b0);
        check("reset bcd",   bcd8,  12'h000);
        check("reset hex",   hex8,  {3{B_BLANK}});
        check("reset hex16", hex16, {5{B_BLANK}});
        rst_n = 1'b1;

        // Zero, ten and full scale, with busy width on the last one.
        run8(8'd0,  12'h000, hex_zero);
        wait8(20);
        run8(8'd10, 12'h010, hex_ten);
        wait8(20);
        busy_cnt8 = 0;
        run8(8'd255, 12'h255, {7'b0010010, 7'b0100100, 7'b0100100});
        wait8(20);
        check("busy cycles 255", busy_cnt8, 8);

        // Table of vectors.
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].bin, vecs[i].bcd, model_hex(20'(vecs[i].bcd), 3)[20:0]);
            wait8(20);
        end

        // A second start during SHIFT must be ignored.
        run8(8'd37, 12'h037, model_hex(20'h00037, 3)[20:0]);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd99;
        @(negedge clk);
        start8 = 1'b0;
        wait8(20);
        repeat (12) @(negedge clk);

        // Reset in the 4th SHIFT cycle aborts; the partial result never appears.
        run8(8'd200, 12'h200, model_hex(20'h00200, 3)[20:0]);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("abort busy", busy8, 1'b0);
        check("abort done", done8, 1'b0);
        check("abort bcd",  bcd8,  12'h000);
        check("abort hex",  hex8,  {3{B_BLANK}});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort no restart", busy8, 1'b0);
        run8(8'd7, 12'h007, model_hex(20'h00007, 3)[20:0]);
        wait8(20);

        // Wide instance: 0xFFFF then 1 back-to-back with start held high.
        @(negedge clk);
        start16 = 1'b1;
        bin16   = 16'hFFFF;
        @(negedge clk);
        bin16   = 16'd1;
        e.bcd   = 20'h65535;
        e.hex   = model_hex(20'h65535, 5);
        e.due   = cyc + 17;
        q16.push_back(e);
        e.bcd   = 20'h00001;
        e.hex   = model_hex(20'h00001, 5);
        e.due   = cyc + 35;
        q16.push_back(e);
        repeat (18) @(negedge clk);
        start16 = 1'b0;
        bin16   = 16'($urandom);
        wait16(40);
        repeat (5) @(negedge clk);
        check("dut16 idle after", busy16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
